// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard scoreboard
package hazard_pkg;

    // Entry fields are stored at fixed widths. Wider than any configuration in
    // use, so narrower ADDR_W/LAT_W values are zero-extended into them.
    localparam int ENT_ADDR_W = 8;
    localparam int ENT_LAT_W  = 4;

    localparam int FWD_RF   = 0;
    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;

    typedef struct packed {
        logic                  vld;
        logic [ENT_ADDR_W-1:0] waddr;
        logic [ENT_LAT_W-1:0]  cnt;
    } entry_t;

    // Saturating decrement of the result-latency countdown.
    function automatic logic [ENT_LAT_W-1:0] cnt_dec(input logic [ENT_LAT_W-1:0] c);
        return (c == '0) ? c : c - ENT_LAT_W'(1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage issue/operand/bypass bundle
// master: ID stage (drives issue info, operands, stage results; receives bypass/stall)
// slave : hazard_scoreboard
interface hazard_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int NSRC   = 2,
    parameter int LAT_W  = 2,
    parameter int SEL_W  = $clog2(DEPTH+1)
);
    logic                     id_valid;
    logic                     id_wen;
    logic [ADDR_W-1:0]        id_waddr;
    logic [LAT_W-1:0]         id_lat;
    logic                     id_kill;
    logic [NSRC-1:0]          src_used;
    logic [NSRC*ADDR_W-1:0]   src_addr;
    logic [NSRC*DATA_W-1:0]   src_rf_data;
    logic [DEPTH*DATA_W-1:0]  stage_data;
    logic [NSRC*SEL_W-1:0]    fwd_sel;
    logic [NSRC*DATA_W-1:0]   fwd_data;
    logic                     stall;

    modport master (
        output id_valid, id_wen, id_waddr, id_lat, id_kill,
               src_used, src_addr, src_rf_data, stage_data,
        input  fwd_sel, fwd_data, stall
    );

    modport slave (
        input  id_valid, id_wen, id_waddr, id_lat, id_kill,
               src_used, src_addr, src_rf_data, stage_data,
        output fwd_sel, fwd_data, stall
    );
endinterface

// File: rtl/hazard_scoreboard_src_match.sv
// rtl/hazard_scoreboard_src_match.sv - youngest-match bypass search for one operand
// in : ent (tracked entries, 0 = youngest), used/addr/rf_data of the operand, stage_data
// out: sel (0 = register file, k+1 = stage k), data (bypassed value), hazard (result not ready)
module src_match
    import hazard_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = $clog2(DEPTH+1)
) (
    input  entry_t [DEPTH-1:0]      ent,
    input  logic                    used,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       rf_data,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    output logic [SEL_W-1:0]        sel,
    output logic [DATA_W-1:0]       data,
    output logic                    hazard
);

    always_comb begin
        logic found;
        sel    = SEL_W'(FWD_RF);
        data   = rf_data;
        hazard = 1'b0;
        found  = 1'b0;
        // r0 is hardwired zero and is never forwarded.
        if (used && addr != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && ent[k].vld && ent[k].waddr == ENT_ADDR_W'(addr)) begin
                    found  = 1'b1;
                    sel    = SEL_W'(k + 1);
                    data   = stage_data[k*DATA_W +: DATA_W];
                    hazard = (ent[k].cnt != '0);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight write tracker with operand bypass and stall
// in : clk, rst_n (async active-low), adv (pipeline advance), hz (slave: issue, operands, stage results)
// out: hz.fwd_sel/fwd_data/stall, stall_cnt (saturating stalled-advance count), occ (valid entries)
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int NSRC   = 2,
    parameter int LAT_W  = 2,
    parameter int SEL_W  = $clog2(DEPTH+1),
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adv,
    hazard_scoreboard_if.slave   hz,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [SEL_W-1:0]     occ
);

    entry_t [DEPTH-1:0] ent_q;
    entry_t [DEPTH-1:0] ent_d;
    logic   [SEL_W-1:0] occ_d;
    logic   [NSRC-1:0]  hazard;
    logic   [SEL_W-1:0] sel_v  [NSRC];
    logic   [DATA_W-1:0] data_v [NSRC];
    logic               ins;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        src_match #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_match (
            .ent        (ent_q),
            .used       (hz.src_used[i]),
            .addr       (hz.src_addr[i*ADDR_W +: ADDR_W]),
            .rf_data    (hz.src_rf_data[i*DATA_W +: DATA_W]),
            .stage_data (hz.stage_data),
            .sel        (sel_v[i]),
            .data       (data_v[i]),
            .hazard     (hazard[i])
        );
    end

    always_comb begin
        hz.fwd_sel  = '0;
        hz.fwd_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            hz.fwd_sel[i*SEL_W +: SEL_W]   = sel_v[i];
            hz.fwd_data[i*DATA_W +: DATA_W] = data_v[i];
        end
    end

    assign hz.stall = |hazard;

    // A stalled ID instruction is re-presented next cycle, so it must not be
    // recorded now; kill simply drops it.
    assign ins = hz.id_valid & hz.id_wen & ~hz.id_kill & ~hz.stall & (hz.id_waddr != '0);

    always_comb begin
        ent_d    = '0;
        occ_d    = '0;
        if (ins) begin
            ent_d[0].vld   = 1'b1;
            ent_d[0].waddr = ENT_ADDR_W'(hz.id_waddr);
            ent_d[0].cnt   = ENT_LAT_W'(hz.id_lat);
        end
        for (int k = 1; k < DEPTH; k++) begin
            ent_d[k]     = ent_q[k-1];
            ent_d[k].cnt = cnt_dec(ent_q[k-1].cnt);
        end
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + SEL_W'(ent_d[k].vld);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q     <= '0;
            occ       <= '0;
            stall_cnt <= '0;
        end else if (adv) begin
            ent_q <= ent_d;
            occ   <= occ_d;
            if (hz.stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 3;
    localparam int NSRC   = 2;
    localparam int LAT_W  = 2;
    localparam int SEL_W  = $clog2(DEPTH+1);
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             adv = 1'b0;
    logic [CNT_W-1:0] stall_cnt;
    logic [SEL_W-1:0] occ;

    hazard_scoreboard_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .NSRC(NSRC), .LAT_W(LAT_W), .SEL_W(SEL_W)
    ) hif ();

    hazard_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NSRC(NSRC),
        .LAT_W(LAT_W), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (adv),
        .hz        (hif),
        .stall_cnt (stall_cnt),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && hif.id_valid && hif.id_wen) begin
            assert (int'(hif.id_lat) < DEPTH) else $error("illegal id_lat %0d", hif.id_lat);
        end
    end

    // Reference model: in-flight writers, youngest at index 0.
    typedef struct { bit vld; int addr; int cnt; } m_ent_t;
    m_ent_t m_q[$];
    int     m_stall_cnt;
    bit     exp_stall;
    int     exp_sel  [NSRC];
    logic [DATA_W-1:0] exp_data [NSRC];

    int n_checks = 0;
    int n_fail   = 0;

    int s_sel [NSRC];
    int s_stall, s_occ, s_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] stage_of(input int k);
        return hif.stage_data[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] rf_of(input int i);
        return hif.src_rf_data[i*DATA_W +: DATA_W];
    endfunction

    task automatic model_clear();
        m_q.delete();
        for (int k = 0; k < DEPTH; k++) m_q.push_back('{vld: 0, addr: 0, cnt: 0});
        m_stall_cnt = 0;
    endtask

    task automatic model_eval();
        exp_stall = 0;
        for (int i = 0; i < NSRC; i++) begin
            int a;
            int hit;
            a   = int'(hif.src_addr[i*ADDR_W +: ADDR_W]);
            hit = -1;
            exp_sel[i]  = 0;
            exp_data[i] = rf_of(i);
            if (hif.src_used[i] && a != 0) begin
                for (int j = 0; j < DEPTH; j++)
                    if (hit < 0 && m_q[j].vld && m_q[j].addr == a) hit = j;
            end
            if (hit >= 0) begin
                if (m_q[hit].cnt > 0) exp_stall = 1;
                else begin
                    exp_sel[i]  = hit + 1;
                    exp_data[i] = stage_of(hit);
                end
            end
        end
    endtask

    task automatic model_adv();
        m_ent_t n;
        if (exp_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        n.vld  = hif.id_valid && hif.id_wen && !hif.id_kill && !exp_stall && hif.id_waddr != 0;
        n.addr = int'(hif.id_waddr);
        n.cnt  = int'(hif.id_lat);
        void'(m_q.pop_back());
        for (int j = 0; j < m_q.size(); j++) if (m_q[j].cnt > 0) m_q[j].cnt--;
        m_q.push_front(n);
    endtask

    function automatic int m_occ();
        int c = 0;
        foreach (m_q[j]) if (m_q[j].vld) c++;
        return c;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < NSRC; i++) hif.src_rf_data[i*DATA_W +: DATA_W] = $urandom;
        for (int k = 0; k < DEPTH; k++) hif.stage_data[k*DATA_W +: DATA_W] = $urandom;
    endtask

    task automatic set_id(input bit v, input bit w, input int wa, input int lat, input bit kill);
        hif.id_valid = v;
        hif.id_wen   = w;
        hif.id_waddr = ADDR_W'(wa);
        hif.id_lat   = LAT_W'(lat);
        hif.id_kill  = kill;
    endtask

    task automatic set_src(input int i, input bit used, input int a);
        hif.src_used[i] = used;
        hif.src_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0);
        for (int i = 0; i < NSRC; i++) set_src(i, 0, 0);
    endtask

    // Called just after a rising edge with inputs already set; checks at
    // mid-cycle, then steps the model across the next rising edge.
    task automatic cycle(input string tag);
        rand_data();
        #4;
        if (!rst_n) model_clear();
        model_eval();
        s_stall = int'(hif.stall);
        s_occ   = int'(occ);
        s_cnt   = int'(stall_cnt);
        chk({tag, "_stall"}, hif.stall, exp_stall);
        for (int i = 0; i < NSRC; i++) begin
            s_sel[i] = int'(hif.fwd_sel[i*SEL_W +: SEL_W]);
            if (!exp_stall) begin
                chk({tag, "_sel"}, hif.fwd_sel[i*SEL_W +: SEL_W], exp_sel[i]);
                chk({tag, "_data"}, hif.fwd_data[i*DATA_W +: DATA_W], exp_data[i]);
            end
        end
        chk({tag, "_occ"}, occ, m_occ());
        chk({tag, "_scnt"}, stall_cnt, m_stall_cnt);
        @(posedge clk);
        if (!rst_n) model_clear();
        else if (adv) model_adv();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        cycle("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        idle();
        rand_data();
        @(posedge clk);
        #1;

        // Reset state
        rst_n = 1'b0;
        adv   = 1'b1;
        cycle("rst0");
        cycle("rst1");
        chk("rst_occ", s_occ, 0);
        chk("rst_cnt", s_cnt, 0);
        chk("rst_stall", s_stall, 0);
        rst_n = 1'b1;

        // ALU producer then consumer
        set_id(1, 1, 3, LAT_ALU, 0);
        cycle("alu_iss");
        idle();
        set_src(0, 1, 3);
        cycle("alu_use");
        chk("alu_nostall", s_stall, 0);
        chk("alu_sel1", s_sel[0], 1);
        cycle("alu_use2");
        chk("alu_sel2", s_sel[0], 2);

        // Load-use: one stall, then forward from stage 1
        do_reset();
        set_id(1, 1, 5, LAT_LOAD, 0);
        cycle("ld_iss");
        set_id(0, 0, 0, 0, 0);
        set_src(0, 1, 5);
        cycle("ld_use");
        chk("ld_stall", s_stall, 1);
        cycle("ld_use2");
        chk("ld_nostall", s_stall, 0);
        chk("ld_sel", s_sel[0], 2);
        chk("ld_cnt", s_cnt, 1);

        // Youngest wins; r0 never forwarded
        idle();
        set_id(1, 1, 7, LAT_ALU, 0);
        cycle("y_iss0");
        set_id(1, 1, 0, LAT_ALU, 0);
        cycle("y_iss1");
        set_id(1, 1, 7, LAT_ALU, 0);
        cycle("y_iss2");
        idle();
        set_src(0, 1, 7);
        set_src(1, 1, 0);
        cycle("y_use");
        chk("y_sel7", s_sel[0], 1);
        chk("y_sel0", s_sel[1], 0);
        chk("y_stall", s_stall, 0);

        // Load held with adv=0: everything frozen
        do_reset();
        set_id(1, 1, 4, LAT_LOAD, 0);
        cycle("fz_iss");
        idle();
        set_src(0, 1, 4);
        adv = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cycle("fz_hold");
            chk("fz_stall", s_stall, 1);
            chk("fz_cnt", s_cnt, 0);
            chk("fz_occ", s_occ, 1);
        end
        adv = 1'b1;
        cycle("fz_rel");
        cycle("fz_after");
        chk("fz_sel", s_sel[0], 2);

        // Asynchronous reset mid-stall with three entries
        do_reset();
        set_id(1, 1, 1, LAT_ALU, 0);
        cycle("ar_i1");
        set_id(1, 1, 2, LAT_ALU, 0);
        cycle("ar_i2");
        set_id(1, 1, 4, LAT_LOAD, 0);
        cycle("ar_i3");
        idle();
        set_src(0, 1, 4);
        rand_data();
        #4;
        chk("ar_pre_stall", hif.stall, 1);
        chk("ar_pre_occ", occ, 3);
        rst_n = 1'b0;
        #1;
        chk("ar_stall", hif.stall, 0);
        chk("ar_occ", occ, 0);
        chk("ar_cnt", stall_cnt, 0);
        chk("ar_sel", hif.fwd_sel[SEL_W-1:0], 0);
        chk("ar_data", hif.fwd_data[DATA_W-1:0], rf_of(0));
        model_clear();
        @(posedge clk);
        #1;
        cycle("ar_hold");
        rst_n = 1'b1;

        // Stall counter saturation: 10 x two-stall lat=2 loads
        idle();
        for (int n = 0; n < 10; n++) begin
            set_id(1, 1, 6, 2, 0);
            set_src(0, 0, 0);
            cycle("sat_iss");
            set_id(0, 0, 0, 0, 0);
            set_src(0, 1, 6);
            cycle("sat_s1");
            cycle("sat_s2");
            cycle("sat_go");
        end
        chk("sat_cnt", s_cnt, CNT_MAX);
        chk("sat_sel", s_sel[0], 3);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            set_id($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                   $urandom_range(0, 7), $urandom_range(0, DEPTH-1),
                   $urandom_range(0, 9) == 0);
            for (int i = 0; i < NSRC; i++)
                set_src(i, $urandom_range(0, 3) != 0, $urandom_range(0, 7));
            adv   = $urandom_range(0, 99) < 85;
            rst_n = $urandom_range(0, 99) >= 2;
            cycle("rnd");
        end
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
